// File: rtl/axilite_wr_if.sv
// AXI-Lite write channel bundle (AW, W, B) used for both requester ports and the
// shared downstream port of axilite_wr_arbiter.
interface axilite_wr_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axilite_wr_arbiter.sv
// Two-requester AXI-Lite write arbiter: one AW/W/B transaction owns the downstream port at a time.
// Optional response watchdog enabled by defining AXILITE_WR_ARB_TIMEOUT_EN.
module axilite_wr_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  axilite_wr_if.slave  s0,
  axilite_wr_if.slave  s1,
  axilite_wr_if.master m
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;            // 0 = s0 owns the port, 1 = s1
  logic   last_grant, last_grant_nxt;
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;

  logic [ADDR_WIDTH-1:0] sel_awaddr;
  logic                  sel_awvalid;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic                  sel_wvalid;
  logic                  sel_bready;

  logic       fwd_awready;
  logic       fwd_wready;
  logic       fwd_bvalid;
  logic [1:0] fwd_bresp;
  logic       aw_hs;
  logic       w_hs;

`ifdef AXILITE_WR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
`endif

  always_comb begin
    sel_awaddr  = grant ? s1.awaddr  : s0.awaddr;
    sel_awvalid = grant ? s1.awvalid : s0.awvalid;
    sel_wdata   = grant ? s1.wdata   : s0.wdata;
    sel_wstrb   = grant ? s1.wstrb   : s0.wstrb;
    sel_wvalid  = grant ? s1.wvalid  : s0.wvalid;
    sel_bready  = grant ? s1.bready  : s0.bready;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    aw_done_nxt    = aw_done;
    w_done_nxt     = w_done;
    m.awaddr       = '0;
    m.awvalid      = 1'b0;
    m.wdata        = '0;
    m.wstrb        = '0;
    m.wvalid       = 1'b0;
    m.bready       = 1'b1;
    fwd_awready    = 1'b0;
    fwd_wready     = 1'b0;
    fwd_bvalid     = 1'b0;
    fwd_bresp      = 2'b00;
    aw_hs          = 1'b0;
    w_hs           = 1'b0;
`ifdef AXILITE_WR_ARB_TIMEOUT_EN
    tmo_cnt_nxt    = tmo_cnt;
`endif

    unique case (state)
      IDLE: begin
        if (s0.awvalid || s1.awvalid) begin
          // Tie goes to whoever was not served last.
          grant_nxt = (s0.awvalid && s1.awvalid) ? ~last_grant : s1.awvalid;
          state_nxt = XFER;
        end
      end

      XFER: begin
        m.awaddr    = sel_awaddr;
        m.wdata     = sel_wdata;
        m.wstrb     = sel_wstrb;
        m.awvalid   = sel_awvalid & ~aw_done;
        m.wvalid    = sel_wvalid & ~w_done;
        fwd_awready = m.awready;
        fwd_wready  = m.wready;
        aw_hs       = sel_awvalid & ~aw_done & m.awready;
        w_hs        = sel_wvalid & ~w_done & m.wready;
        aw_done_nxt = aw_done | aw_hs;
        w_done_nxt  = w_done | w_hs;
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt = RESP;
`ifdef AXILITE_WR_ARB_TIMEOUT_EN
          tmo_cnt_nxt = '0;
`endif
        end
      end

      RESP: begin
        fwd_bvalid = m.bvalid;
        fwd_bresp  = m.bresp;
        m.bready   = sel_bready;
`ifdef AXILITE_WR_ARB_TIMEOUT_EN
        // Watchdog fired: answer SLVERR ourselves and drain anything downstream sends.
        if (tmo_hit) begin
          fwd_bvalid = 1'b1;
          fwd_bresp  = 2'b10;
          m.bready   = 1'b1;
        end else if (!m.bvalid) begin
          tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
        end
`endif
        if (fwd_bvalid && sel_bready) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
          aw_done_nxt    = 1'b0;
          w_done_nxt     = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Only the owner sees ready/response; the other requester is held quiet.
  always_comb begin
    s0.awready = fwd_awready & ~grant;
    s1.awready = fwd_awready & grant;
    s0.wready  = fwd_wready & ~grant;
    s1.wready  = fwd_wready & grant;
    s0.bvalid  = fwd_bvalid & ~grant;
    s1.bvalid  = fwd_bvalid & grant;
    s0.bresp   = grant ? 2'b00 : fwd_bresp;
    s1.bresp   = grant ? fwd_bresp : 2'b00;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
`ifdef AXILITE_WR_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
`ifdef AXILITE_WR_ARB_TIMEOUT_EN
      tmo_cnt    <= tmo_cnt_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_axilite_wr_arbiter.sv
// Directed bench for axilite_wr_arbiter with a transaction-level ownership model
// compared against every DUT output on each falling clock edge.
module tb_axilite_wr_arbiter;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int TMO = 16;
`ifdef AXILITE_WR_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  axilite_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0_if ();
  axilite_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s1_if ();
  axilite_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

  axilite_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .s0  (s0_if),
    .s1  (s1_if),
    .m   (m_if)
  );

  // Requester-side stimulus
  logic [AW-1:0] s_awaddr [2];
  logic          s_awvalid[2];
  logic [DW-1:0] s_wdata  [2];
  logic [7:0]    s_wstrb  [2];
  logic          s_wvalid [2];
  logic          s_bready [2];
  // Downstream-side stimulus
  logic          m_awready;
  logic          m_wready;
  logic          m_bvalid;
  logic [1:0]    m_bresp;

  assign s0_if.awaddr  = s_awaddr[0];
  assign s0_if.awvalid = s_awvalid[0];
  assign s0_if.wdata   = s_wdata[0];
  assign s0_if.wstrb   = s_wstrb[0];
  assign s0_if.wvalid  = s_wvalid[0];
  assign s0_if.bready  = s_bready[0];
  assign s1_if.awaddr  = s_awaddr[1];
  assign s1_if.awvalid = s_awvalid[1];
  assign s1_if.wdata   = s_wdata[1];
  assign s1_if.wstrb   = s_wstrb[1];
  assign s1_if.wvalid  = s_wvalid[1];
  assign s1_if.bready  = s_bready[1];
  assign m_if.awready  = m_awready;
  assign m_if.wready   = m_wready;
  assign m_if.bvalid   = m_bvalid;
  assign m_if.bresp    = m_bresp;

  logic [1:0]      a_awready, a_wready, a_bvalid;
  logic [1:0][1:0] a_bresp;
  assign a_awready = {s1_if.awready, s0_if.awready};
  assign a_wready  = {s1_if.wready,  s0_if.wready};
  assign a_bvalid  = {s1_if.bvalid,  s0_if.bvalid};
  assign a_bresp   = {s1_if.bresp,   s0_if.bresp};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // owner: -1 when the port is free, else the requester holding it.
  int owner    = -1;
  bit aw_ok    = 1'b0;
  bit w_ok     = 1'b0;
  int prefer   = 0;   // requester that wins a tie
  int wait_cyc = 0;   // response-phase cycles spent without a downstream B

  typedef struct packed {
    logic [63:0]     m_awaddr;
    logic            m_awvalid;
    logic [63:0]     m_wdata;
    logic [7:0]      m_wstrb;
    logic            m_wvalid;
    logic            m_bready;
    logic [1:0]      awready;
    logic [1:0]      wready;
    logic [1:0]      bvalid;
    logic [1:0][1:0] bresp;
  } exp_t;

  function automatic exp_t expect_out();
    exp_t e;
    e = '0;
    e.m_bready = 1'b1;
    if (owner >= 0 && !(aw_ok && w_ok)) begin
      e.m_awaddr       = s_awaddr[owner];
      e.m_wdata        = s_wdata[owner];
      e.m_wstrb        = s_wstrb[owner];
      e.m_awvalid      = s_awvalid[owner] && !aw_ok;
      e.m_wvalid       = s_wvalid[owner] && !w_ok;
      e.awready[owner] = m_awready;
      e.wready[owner]  = m_wready;
    end else if (owner >= 0) begin
      if (TMO_EN && wait_cyc == TMO) begin
        e.bvalid[owner] = 1'b1;
        e.bresp[owner]  = 2'b10;
        e.m_bready      = 1'b1;
      end else begin
        e.bvalid[owner] = m_bvalid;
        e.bresp[owner]  = m_bresp;
        e.m_bready      = s_bready[owner];
      end
    end
    return e;
  endfunction

  initial begin : model
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        owner = -1; aw_ok = 1'b0; w_ok = 1'b0; prefer = 0; wait_cyc = 0;
      end else begin
        e = expect_out();
        if (owner < 0) begin
          if (s_awvalid[0] || s_awvalid[1]) begin
            owner    = (s_awvalid[0] && s_awvalid[1]) ? prefer : (s_awvalid[1] ? 1 : 0);
            aw_ok    = 1'b0;
            w_ok     = 1'b0;
            wait_cyc = 0;
          end
        end else if (!(aw_ok && w_ok)) begin
          if (e.m_awvalid && m_awready) aw_ok = 1'b1;
          if (e.m_wvalid && m_wready) w_ok = 1'b1;
        end else if (e.bvalid[owner] && s_bready[owner]) begin
          prefer = 1 - owner;
          owner  = -1;
        end else if (!m_bvalid && !(TMO_EN && wait_cyc == TMO)) begin
          wait_cyc++;
        end
      end
    end
  end

  int b_hs_cnt[2] = '{0, 0};

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      e = expect_out();
      check("m_awaddr",  m_if.awaddr,  e.m_awaddr);
      check("m_awvalid", m_if.awvalid, e.m_awvalid);
      check("m_wdata",   m_if.wdata,   e.m_wdata);
      check("m_wstrb",   m_if.wstrb,   e.m_wstrb);
      check("m_wvalid",  m_if.wvalid,  e.m_wvalid);
      check("m_bready",  m_if.bready,  e.m_bready);
      check("s_awready", a_awready,    e.awready);
      check("s_wready",  a_wready,     e.wready);
      check("s_bvalid",  a_bvalid,     e.bvalid);
      check("s_bresp",   a_bresp,      e.bresp);
      for (int i = 0; i < 2; i++)
        if (a_bvalid[i] && s_bready[i]) b_hs_cnt[i]++;
    end
  end

  // ---------------- downstream responder ----------------
  bit           b_auto    = 1'b1;
  logic [1:0]   slv_bresp = 2'b00;
  int           slv_aw = 0, slv_w = 0, slv_b = 0;
  int           wv_cyc = 0;
  logic [AW-1:0] aw_log[$];

  initial begin : downstream
    forever begin
      @(negedge clk);
      if (rst) begin
        slv_aw = 0; slv_w = 0; slv_b = 0;
      end else begin
        if (m_if.awvalid && m_awready) begin
          slv_aw++;
          aw_log.push_back(m_if.awaddr);
        end
        if (m_if.wvalid) wv_cyc++;
        if (m_if.wvalid && m_wready) slv_w++;
        if (b_auto && m_bvalid && m_if.bready) slv_b++;
      end
      @(posedge clk);
      #1;
      if (b_auto) begin
        m_bvalid = (((slv_aw < slv_w) ? slv_aw : slv_w) > slv_b);
        m_bresp  = slv_bresp;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One full requester write; returns after the B handshake or a 200-cycle budget.
  task automatic req_write(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [7:0] st, output logic [1:0] br, output logic ok);
    bit aw_hs, w_hs, b_hs;
    int cyc;
    s_awaddr[n] = a; s_wdata[n] = d; s_wstrb[n] = st;
    s_awvalid[n] = 1'b1; s_wvalid[n] = 1'b1;
    ok = 1'b0; br = 2'b00; cyc = 0;
    while (!ok && cyc < 200) begin
      @(negedge clk);
      aw_hs = s_awvalid[n] && a_awready[n];
      w_hs  = s_wvalid[n] && a_wready[n];
      b_hs  = a_bvalid[n] && s_bready[n];
      if (b_hs) begin br = a_bresp[n]; ok = 1'b1; end
      tick();
      if (aw_hs) s_awvalid[n] = 1'b0;
      if (w_hs)  s_wvalid[n]  = 1'b0;
      cyc++;
    end
    s_awvalid[n] = 1'b0;
    s_wvalid[n]  = 1'b0;
    if (!ok) check($sformatf("req%0d_b_budget", n), 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [1:0] br0, br1;
    logic       ok0, ok1;
    int         b0;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_awaddr[i] = '0; s_awvalid[i] = 1'b0; s_wdata[i] = '0;
      s_wstrb[i] = '0; s_wvalid[i] = 1'b0; s_bready[i] = 1'b1;
    end
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;

    // Reset values
    @(negedge clk);
    check("rst_m_bready",  m_if.bready,  1);
    check("rst_m_awvalid", m_if.awvalid, 0);
    check("rst_m_wvalid",  m_if.wvalid,  0);
    check("rst_s0_bvalid", s0_if.bvalid, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single s0 write: m_awvalid appears exactly one cycle after awvalid
    fork
      req_write(0, 64'h100, 64'hDEAD_BEEF, 8'hFF, br0, ok0);
      begin
        @(negedge clk);
        check("r028_awvalid_T", m_if.awvalid, 0);
        @(negedge clk);
        check("r028_awvalid_T1", m_if.awvalid, 1);
        check("r028_awaddr", m_if.awaddr, 64'h100);
        check("r028_wdata", m_if.wdata, 64'hDEAD_BEEF);
      end
    join
    check("r028_ok", ok0, 1);
    check("r028_bresp", br0, 2'b00);
    check("r028_b_count", b_hs_cnt[0], 1);
    @(negedge clk);
    check("r028_idle_bready", m_if.bready, 1);

    // Simultaneous pairs after reset: grants alternate starting with s0
    pulse_reset();
    aw_log.delete();
    for (int k = 0; k < 5; k++) begin
      fork
        req_write(0, 64'h1000 + 64'(k), 64'h11 * 64'(k + 1), 8'h0F, br0, ok0);
        req_write(1, 64'h2000 + 64'(k), 64'h22 * 64'(k + 1), 8'hF0, br1, ok1);
      join
    end
    check("r029_log_size", aw_log.size(), 10);
    for (int i = 0; i < 10 && i < aw_log.size(); i++)
      check($sformatf("r029_order%0d", i), aw_log[i],
            ((i % 2) == 0) ? 64'h1000 + 64'(i / 2) : 64'h2000 + 64'(i / 2));

    // Back-to-back: s0 re-requests right after its B and loses to pending s1
    aw_log.delete();
    fork
      begin
        req_write(0, 64'hA1, 64'h1, 8'hFF, br0, ok0);
        req_write(0, 64'hA2, 64'h2, 8'hFF, br0, ok0);
      end
      begin
        tick();
        req_write(1, 64'hB1, 64'h3, 8'hFF, br1, ok1);
      end
    join
    check("r023_log_size", aw_log.size(), 3);
    if (aw_log.size() == 3) begin
      check("r023_first", aw_log[0], 64'hA1);
      check("r023_second", aw_log[1], 64'hB1);
      check("r023_third", aw_log[2], 64'hA2);
    end

    // W accepted 3 cycles before AW; downstream returns DECERR
    aw_log.delete();
    wv_cyc    = 0;
    m_awready = 1'b0;
    slv_bresp = 2'b11;
    fork
      req_write(0, 64'h300, 64'h3333, 8'h3C, br0, ok0);
      begin
        repeat (4) @(posedge clk);
        #1;
        m_awready = 1'b1;
      end
    join
    slv_bresp = 2'b00;
    check("r030_wvalid_cycles", wv_cyc, 1);
    check("r030_aw_handshakes", aw_log.size(), 1);
    check("r030_ok", ok0, 1);
    check("r030_bresp", br0, 2'b11);

    // Reset in XFER after AW accepted, W still pending
    aw_log.delete();
    b0       = b_hs_cnt[0];
    m_wready = 1'b0;
    s_awaddr[0] = 64'h400; s_wdata[0] = 64'h4444; s_wstrb[0] = 8'hFF;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1;
    tick();
    tick();
    s_awvalid[0] = 1'b0;
    s_wvalid[0]  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("r031_awvalid", m_if.awvalid, 0);
    check("r031_wvalid",  m_if.wvalid,  0);
    check("r031_bready",  m_if.bready,  1);
    check("r031_awaddr",  m_if.awaddr,  0);
    check("r031_wdata",   m_if.wdata,   0);
    check("r031_s0_awready", s0_if.awready, 0);
    tick();
    rst      = 1'b0;
    m_wready = 1'b1;
    req_write(1, 64'h500, 64'h5555, 8'hFF, br1, ok1);
    check("r031_s1_ok", ok1, 1);
    check("r031_s1_bresp", br1, 2'b00);
    check("r031_last_aw", aw_log[aw_log.size() - 1], 64'h500);
    check("r031_no_stray_b", b_hs_cnt[0], b0);

    // Downstream never responds: watchdog (if built in) answers SLVERR after 16 RESP cycles
    b_auto   = 1'b0;
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    tick();
    fork
      req_write(0, 64'h600, 64'h6666, 8'hFF, br0, ok0);
      begin
        repeat (17) @(posedge clk);
        @(negedge clk);
        check("r032_bvalid_before", s0_if.bvalid, 0);
        @(negedge clk);
`ifdef AXILITE_WR_ARB_TIMEOUT_EN
        check("r032_bvalid_at", s0_if.bvalid, 1);
        check("r032_bresp_at", s0_if.bresp, 2'b10);
`else
        check("r027_still_waiting", s0_if.bvalid, 0);
        repeat (10) tick();
        m_bvalid = 1'b1;
        @(negedge clk);
        check("r027_b_forwarded", s0_if.bvalid, 1);
        tick();
        m_bvalid = 1'b0;
`endif
      end
    join
    check("r032_ok", ok0, 1);
    check("r032_bresp", br0, TMO_EN ? 2'b10 : 2'b00);

    // Late downstream B is absorbed, not forwarded
    tick();
    m_bvalid = 1'b1;
    m_bresp  = 2'b01;
    @(negedge clk);
    check("late_b_s0", s0_if.bvalid, 0);
    check("late_b_s1", s1_if.bvalid, 0);
    check("late_b_bready", m_if.bready, 1);
    tick();
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
